// File: rtl/cic_downsample.sv
// CIC decimator: STAGES integrators at the input rate, decimate by R, STAGES combs
// with differential delay N at the output rate. All arithmetic wraps at DW bits.
module cic_downsample #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int R       = 32,
  parameter int N       = 1,
  parameter int STAGES  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_i_en,
  input  logic [width_H+width_W-1:0]   data_i,
  output logic                         data_o_en,
  output logic [width_H+width_W-1:0]   data_o
);

  localparam int DW = width_H + width_W;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic [DW-1:0]     r_int [STAGES];
  logic [CW-1:0]     r_cnt;
  logic              r_dec_en;
  logic [DW-1:0]     r_dec;
  logic [DW-1:0]     r_c   [STAGES];
  logic [DW-1:0]     r_dly [STAGES][N];
  logic [STAGES:1]   r_en_c;

  logic [DW-1:0]     w_comb_in [STAGES];
  logic [STAGES-1:0] w_en_c;

  // Stage 0 is fed by the decimation register; later stages chain off the previous comb.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb_in
    if (k == 0) begin : g_first
      assign w_comb_in[k] = r_dec;
      assign w_en_c[k]    = r_dec_en;
    end else begin : g_rest
      assign w_comb_in[k] = r_c[k-1];
      assign w_en_c[k]    = r_en_c[k];
    end
  end

  // Integrator chain and decimation counter, advanced only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_int[k] <= '0;
      end
      r_cnt    <= '0;
      r_dec    <= '0;
      r_dec_en <= 1'b0;
    end else if (data_i_en) begin
      r_int[0] <= r_int[0] + data_i;
      for (int k = 1; k < STAGES; k++) begin
        r_int[k] <= r_int[k] + r_int[k-1];
      end
      if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_dec    <= r_int[STAGES-1];
        r_dec_en <= 1'b1;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
        r_dec_en <= 1'b0;
      end
    end else begin
      r_dec_en <= 1'b0;
    end
  end

  // Comb pipeline: each stage fires one edge after its predecessor and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_c[k] <= '0;
        for (int j = 0; j < N; j++) begin
          r_dly[k][j] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_en_c[k+1] <= w_en_c[k];
        if (w_en_c[k]) begin
          r_c[k]      <= w_comb_in[k] - r_dly[k][N-1];
          r_dly[k][0] <= w_comb_in[k];
          for (int j = 1; j < N; j++) begin
            r_dly[k][j] <= r_dly[k][j-1];
          end
        end else begin
          r_c[k] <= r_c[k];
        end
      end
    end
  end

  assign data_o    = r_c[STAGES-1];
  assign data_o_en = r_en_c[STAGES];

endmodule

// File: tb/tb_cic_downsample.sv
// Scoreboard bench for cic_downsample: four parameterisations, a wrapping reference
// model pushes expected outputs with their due cycle; a negedge monitor pops and compares.
module tb_cic_downsample;

  localparam int P_S  [4] = '{1, 3, 2, 1};
  localparam int P_R  [4] = '{4, 4, 4, 32};
  localparam int P_N  [4] = '{1, 1, 2, 1};
  localparam int P_DW [4] = '{25, 26, 12, 25};

  typedef struct {
    int     id;
    longint v;
    int     due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i [4];
  logic        en_i  [4];
  logic [25:0] d_in  [4];
  logic        o_en  [4];
  logic [63:0] o_dat [4];
  logic [24:0] out_a;
  logic [25:0] out_b;
  logic [11:0] out_c;
  logic [24:0] out_d;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  exp_t   q[$];
  exp_t   pe;
  longint last_out [4];
  longint m_int [4][3];
  longint m_dly [4][3][2];
  int     m_cnt [4];

  assign o_dat[0] = {39'd0, out_a};
  assign o_dat[1] = {38'd0, out_b};
  assign o_dat[2] = {52'd0, out_c};
  assign o_dat[3] = {39'd0, out_d};

  cic_downsample #(.width_H(5), .width_W(20), .R(4), .N(1), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst_i[0]), .data_i_en(en_i[0]), .data_i(d_in[0][24:0]),
    .data_o_en(o_en[0]), .data_o(out_a));
  cic_downsample #(.width_H(6), .width_W(20), .R(4), .N(1), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst_i[1]), .data_i_en(en_i[1]), .data_i(d_in[1][25:0]),
    .data_o_en(o_en[1]), .data_o(out_b));
  cic_downsample #(.width_H(6), .width_W(6), .R(4), .N(2), .STAGES(2)) dut_c (
    .clk(clk), .rst(rst_i[2]), .data_i_en(en_i[2]), .data_i(d_in[2][11:0]),
    .data_o_en(o_en[2]), .data_o(out_c));
  cic_downsample dut_d (
    .clk(clk), .rst(rst_i[3]), .data_i_en(en_i[3]), .data_i(d_in[3][24:0]),
    .data_o_en(o_en[3]), .data_o(out_d));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic longint wrap(input longint v, input int dw);
    return v & ((longint'(1) << dw) - 1);
  endfunction

  // Reference model: the defining filter equations, applied per accepted sample.
  task automatic model_step(input int id, input longint x, input int e);
    longint pre, v, o;
    int dw;
    dw  = P_DW[id];
    pre = m_int[id][P_S[id]-1];
    for (int k = P_S[id] - 1; k >= 1; k--)
      m_int[id][k] = wrap(m_int[id][k] + m_int[id][k-1], dw);
    m_int[id][0] = wrap(m_int[id][0] + x, dw);
    if (m_cnt[id] == P_R[id] - 1) begin
      m_cnt[id] = 0;
      v = pre;
      for (int k = 0; k < P_S[id]; k++) begin
        o = wrap(v - m_dly[id][k][P_N[id]-1], dw);
        for (int j = P_N[id] - 1; j >= 1; j--) m_dly[id][k][j] = m_dly[id][k][j-1];
        m_dly[id][k][0] = v;
        v = o;
      end
      q.push_back('{id: id, v: v, due: e + P_S[id]});
    end else begin
      m_cnt[id]++;
    end
  endtask

  task automatic model_clear(input int id);
    m_cnt[id] = 0;
    for (int k = 0; k < 3; k++) begin
      m_int[id][k] = 0;
      m_dly[id][k][0] = 0;
      m_dly[id][k][1] = 0;
    end
  endtask

  task automatic drive(input int id, input bit en, input longint x);
    en_i[id] = en;
    d_in[id] = 26'(wrap(x, P_DW[id]));
    if (en) model_step(id, wrap(x, P_DW[id]), cyc + 1);
    @(posedge clk);
    #1;
    en_i[id] = 1'b0;
  endtask

  task automatic reset_dut(input int id);
    int r;
    rst_i[id] = 1'b1;
    en_i[id]  = 1'b1;
    d_in[id]  = 26'd5;
    r = cyc + 1;
    @(posedge clk);
    #1;
    rst_i[id] = 1'b0;
    en_i[id]  = 1'b0;
    model_clear(id);
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].id == id && q[k].due >= r) q.delete(k);
    check_val("rst_en", longint'(o_en[id]), 0);
    check_val("rst_dat", longint'(o_dat[id]), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    #1;
    check_val("drain_pending", q.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (o_en[i] === 1'b1) begin
        last_out[i] = longint'(o_dat[i]);
        if (q.size() == 0) begin
          check_val("unexpected_pulse", i, -1);
        end else begin
          pe = q.pop_front();
          check_val("pulse_dut", i, pe.id);
          check_val("out_val", longint'(o_dat[i]), pe.v);
          check_val("out_cycle", cyc, pe.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_i[i] = 1'b1;
      en_i[i]  = 1'b0;
      d_in[i]  = 26'd0;
      last_out[i] = -1;
      model_clear(i);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rst_i[i] = 1'b0;
      check_val("reset_en", longint'(o_en[i]), 0);
      check_val("reset_dat", longint'(o_dat[i]), 0);
    end

    // Impulse: 1, then 0 forever
    drive(0, 1'b1, 1);
    for (int n = 0; n < 23; n++) drive(0, 1'b1, 0);
    drain();
    check_val("impulse_tail", last_out[0], 0);

    // DC gain, continuous enable
    for (int n = 0; n < 40; n++) drive(1, 1'b1, 1);
    drain();
    check_val("dc_pos", last_out[1], 64);

    // DC gain, enable one cycle in three
    reset_dut(1);
    last_out[1] = -1;
    for (int n = 0; n < 40; n++) begin
      drive(1, 1'b1, 1);
      drive(1, 1'b0, 0);
      drive(1, 1'b0, 0);
    end
    drain();
    check_val("dc_gapped", last_out[1], 64);

    // Negative DC with integrator wrap
    for (int n = 0; n < 60; n++) drive(2, 1'b1, -3);
    drain();
    check_val("dc_neg_wrap", last_out[2], wrap(-192, 12));

    // Reset with a comb strobe in flight, then mid-group, then random data
    for (int n = 0; n < 4; n++) drive(0, 1'b1, 7);
    reset_dut(0);
    drive(0, 1'b1, 9);
    drive(0, 1'b1, 9);
    reset_dut(0);
    for (int n = 0; n < 24; n++) begin
      drive(0, 1'b1, longint'($urandom_range(0, 2000)) - 1000);
      if ($urandom_range(0, 3) == 0) drive(0, 1'b0, 0);
    end
    drain();

    // Default parameters, full-scale input
    for (int n = 0; n < 200; n++) drive(3, 1'b1, (longint'(1) << 19) - 1);
    drain();
    check_val("full_scale", last_out[3], ((longint'(1) << 19) - 1) * 32);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
